// File: rtl/shot_pkg.sv
// Shared types and widths for the billiard turn controller.
// Holds the FSM encoding and score saturation helper.
package shot_pkg;

  typedef enum logic [2:0] {
    AIM       = 3'd0,
    CHARGE    = 3'd1,
    STRIKE    = 3'd2,
    ROLL      = 3'd3,
    EVAL      = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam int SCORE_W = 4;
  localparam int POWER_W = 5;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic [SCORE_W-1:0] sat_score(
    input logic [SCORE_W:0] s
  );
    return s[SCORE_W] ? SCORE_MAX : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/ball_popcount.sv
// Combinational bit counter over the object-ball mask.
// Used to count newly pocketed balls in one evaluation.
module ball_popcount #(
  parameter int W  = 3,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++)
      o_count = o_count + CW'(i_bits[i]);
  end

endmodule

// File: rtl/shot_sequencer.sv
// Turn-level billiard controller: cue charge, strike, settle wait,
// pocket evaluation, scoring, turn hand-over and game-over detection.
module shot_sequencer
  import shot_pkg::*;
#(
  parameter int NUM_BALLS     = 4,
  parameter int SETTLE_FRAMES = 8,
  parameter int MAX_POWER     = 24,
  parameter int POWER_STEP    = 1,
  parameter int VEL_SCALE     = 4,
  parameter int ROLL_TIMEOUT  = 1800
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 shoot_btn,
  input  logic signed [31:0]   aim_dx,
  input  logic signed [31:0]   aim_dy,
  input  logic [NUM_BALLS-1:0] ball_moving,
  input  logic [NUM_BALLS-1:0] scored,
  output logic                 strike,
  output logic signed [31:0]   strike_velocityX,
  output logic signed [31:0]   strike_velocityY,
  output logic                 white_respawn,
  output logic                 current_player,
  output logic [SCORE_W-1:0]   score_p0,
  output logic [SCORE_W-1:0]   score_p1,
  output logic [POWER_W-1:0]   power,
  output logic [2:0]           state_o,
  output logic                 game_over
);

  localparam int CW = $clog2(NUM_BALLS);
  localparam int SW = $clog2(SETTLE_FRAMES+1);
  localparam int FW = $clog2(ROLL_TIMEOUT+1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_FRAMES);
  localparam logic [FW-1:0] FRAME_END  = FW'(ROLL_TIMEOUT);
  localparam logic [POWER_W:0] PMAX  = (POWER_W+1)'(MAX_POWER);
  localparam logic [POWER_W:0] PSTEP = (POWER_W+1)'(POWER_STEP);

  state_t r_state, w_next;

  logic                 r_btn_prev;
  logic [POWER_W-1:0]   r_power;
  logic signed [31:0]   r_vx, r_vy;
  logic [NUM_BALLS-1:0] r_shot, r_pocketed;
  logic [SW-1:0]        r_settle;
  logic [FW-1:0]        r_frame;
  logic [SCORE_W-1:0]   r_score0, r_score1;
  logic                 r_player;
  logic                 r_respawn;

  logic                 w_press;
  logic [NUM_BALLS-1:0] w_shot, w_pocketed_nxt;
  logic [NUM_BALLS-2:0] w_new;
  logic [CW-1:0]        w_n;
  logic                 w_foul, w_all;
  logic [SW-1:0]        w_settle_nxt;
  logic [FW-1:0]        w_frame_nxt;
  logic                 w_roll_done;
  logic [POWER_W:0]     w_pinc;
  logic [POWER_W-1:0]   w_pow_nxt;
  logic signed [31:0]   w_pow_s, w_vx, w_vy;
  logic [SCORE_W:0]     w_sum;

  assign w_press = shoot_btn & ~r_btn_prev & ~|ball_moving;

  // Pocket pulses landing in the EVAL cycle still count for this shot.
  assign w_shot = r_shot | scored;
  assign w_new  = w_shot[NUM_BALLS-1:1] & ~r_pocketed[NUM_BALLS-1:1];
  assign w_foul = w_shot[0];
  assign w_pocketed_nxt = r_pocketed | {w_shot[NUM_BALLS-1:1], 1'b0};
  assign w_all  = &w_pocketed_nxt[NUM_BALLS-1:1];

  ball_popcount #(
    .W  (NUM_BALLS-1),
    .CW (CW)
  ) u_pop (
    .i_bits  (w_new),
    .o_count (w_n)
  );

  assign w_settle_nxt = |ball_moving ? '0 : r_settle + SW'(1);
  assign w_frame_nxt  = r_frame + FW'(1);
  assign w_roll_done  = startOfFrame &&
                        (w_settle_nxt == SETTLE_END ||
                         w_frame_nxt == FRAME_END);

  assign w_pinc    = {1'b0, r_power} + PSTEP;
  assign w_pow_nxt = (w_pinc > PMAX) ? PMAX[POWER_W-1:0]
                                     : w_pinc[POWER_W-1:0];

  assign w_pow_s = {{(32-POWER_W){1'b0}}, r_power};
  assign w_vx    = w_pow_s * aim_dx * VEL_SCALE;
  assign w_vy    = w_pow_s * aim_dy * VEL_SCALE;

  assign w_sum = {1'b0, r_player ? r_score1 : r_score0}
               + (SCORE_W+1)'(w_n);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= AIM;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      AIM:       if (w_press) w_next = CHARGE;
      CHARGE:    if (!shoot_btn)
                   w_next = (r_power == '0) ? AIM : STRIKE;
      STRIKE:    w_next = ROLL;
      ROLL:      if (w_roll_done) w_next = EVAL;
      EVAL:      w_next = w_all ? GAME_OVER : AIM;
      GAME_OVER: w_next = GAME_OVER;
      default:   w_next = AIM;
    endcase
  end

  always_comb begin
    strike           = (r_state == STRIKE);
    game_over        = (r_state == GAME_OVER);
    state_o          = r_state;
    strike_velocityX = r_vx;
    strike_velocityY = r_vy;
    white_respawn    = r_respawn;
    current_player   = r_player;
    score_p0         = r_score0;
    score_p1         = r_score1;
    power            = r_power;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_btn_prev <= 1'b0;
      r_power    <= '0;
      r_vx       <= '0;
      r_vy       <= '0;
      r_shot     <= '0;
      r_pocketed <= '0;
      r_settle   <= '0;
      r_frame    <= '0;
      r_score0   <= '0;
      r_score1   <= '0;
      r_player   <= 1'b0;
      r_respawn  <= 1'b0;
    end else begin
      r_btn_prev <= shoot_btn;
      r_respawn  <= (r_state == EVAL) && w_foul;
      unique case (r_state)
        AIM: if (w_press) r_power <= '0;
        CHARGE: begin
          // Release wins over a coincident frame tick.
          if (!shoot_btn) begin
            if (r_power != '0) begin
              r_vx <= w_vx;
              r_vy <= w_vy;
            end
          end else if (startOfFrame) begin
            r_power <= w_pow_nxt;
          end
        end
        STRIKE: begin
          r_shot   <= scored;
          r_settle <= '0;
          r_frame  <= '0;
        end
        ROLL: begin
          r_shot <= w_shot;
          if (startOfFrame) begin
            r_settle <= w_settle_nxt;
            r_frame  <= w_frame_nxt;
          end
          if (w_roll_done) r_power <= '0;
        end
        EVAL: begin
          r_pocketed <= w_pocketed_nxt;
          r_shot     <= w_shot;
          if (!w_foul && w_n != '0) begin
            if (r_player) r_score1 <= sat_score(w_sum);
            else          r_score0 <= sat_score(w_sum);
          end
          if (w_foul || w_n == '0) r_player <= ~r_player;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer: directed and random shots
// checked against a turn-level game model.
module tb_shot_sequencer;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               sof = 1'b0;
  logic               btn = 1'b0;
  logic signed [31:0] dx = 0, dy = 0;
  logic [3:0]         mov = '0, scd = '0;

  logic               strike, white_respawn, current_player, game_over;
  logic signed [31:0] vx, vy;
  logic [3:0]         score_p0, score_p1;
  logic [4:0]         power;
  logic [2:0]         state_o;

  shot_sequencer dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (sof),
    .shoot_btn        (btn),
    .aim_dx           (dx),
    .aim_dy           (dy),
    .ball_moving      (mov),
    .scored           (scd),
    .strike           (strike),
    .strike_velocityX (vx),
    .strike_velocityY (vy),
    .white_respawn    (white_respawn),
    .current_player   (current_player),
    .score_p0         (score_p0),
    .score_p1         (score_p1),
    .power            (power),
    .state_o          (state_o),
    .game_over        (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  typedef struct { int vx; int vy; int pw; } strike_t;
  typedef struct { int s0; int s1; int pl; int go; int rs; } res_t;

  strike_t sq[$];
  res_t    rq[$];
  int      eq[$];
  int      exp_resp = 0, seen_resp = 0;

  bit [3:0] m_pock;
  int       m_s0, m_s1, m_pl;
  bit       m_go;

  task automatic model_reset();
    m_pock = '0; m_s0 = 0; m_s1 = 0; m_pl = 0; m_go = 0;
  endtask

  task automatic model_eval(input bit [3:0] mask);
    bit [3:0] nw;
    int n;
    res_t r;
    nw = mask & ~m_pock;
    nw[0] = 1'b0;
    n = $countones(nw);
    if (mask[0]) begin
      m_pl = 1 - m_pl;
      exp_resp++;
    end else if (n > 0) begin
      if (m_pl == 0) m_s0 = (m_s0 + n > 15) ? 15 : m_s0 + n;
      else           m_s1 = (m_s1 + n > 15) ? 15 : m_s1 + n;
    end else begin
      m_pl = 1 - m_pl;
    end
    m_pock = m_pock | (mask & 4'b1110);
    m_go = (m_pock[3:1] == 3'b111);
    r.s0 = m_s0; r.s1 = m_s1; r.pl = m_pl;
    r.go = int'(m_go); r.rs = int'(mask[0]);
    rq.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    btn = 1'b0; sof = 1'b0; mov = '0; scd = '0;
    step();
    model_reset();
    resetN = 1'b1;
    step();
  endtask

  task automatic shot(input int hold, input int ax, input int ay,
                      input int moves, input bit tmo, input bit rel_sof,
                      input logic [3:0] pk_drop, input logic [3:0] pk_s,
                      input logic [3:0] pk_a, input logic [3:0] pk_b);
    int p;
    strike_t s;
    scd = pk_drop; btn = 1'b1;
    step();
    scd = '0;
    for (int i = 0; i < hold; i++) begin
      sof = 1'b1; step(); sof = 1'b0; step();
    end
    dx = ax; dy = ay; btn = 1'b0; sof = rel_sof;
    step();
    sof = 1'b0;
    p = (hold > 24) ? 24 : hold;
    if (p == 0) begin
      step();
      return;
    end
    s.vx = p * ax * 4; s.vy = p * ay * 4; s.pw = p;
    sq.push_back(s);
    scd = pk_s; step();
    scd = pk_a; step();
    scd = '0;
    if (tmo) begin
      mov = 4'b0001;
      for (int f = 1; f <= 1800; f++) begin
        sof = 1'b1; step(); sof = 1'b0;
        if (f < 1800) step();
      end
    end else begin
      mov = 4'b0010 | 4'($urandom_range(0, 15));
      for (int f = 0; f < moves; f++) begin
        sof = 1'b1; step(); sof = 1'b0; step();
      end
      mov = '0;
      for (int f = 1; f <= 8; f++) begin
        sof = 1'b1; step(); sof = 1'b0;
        if (f < 8) step();
      end
    end
    eq.push_back(cyc);
    mov = '0;
    scd = pk_b; step();
    scd = '0;
    model_eval(pk_s | pk_a | pk_b);
    step();
  endtask

  bit pend = 1'b0;

  always @(negedge clk) begin
    if (!resetN) begin
      pend = 1'b0;
    end else begin
      if (white_respawn) seen_resp++;
      if (pend) begin
        pend = 1'b0;
        if (rq.size() == 0) miss("eval_result_unexpected");
        else begin
          res_t r;
          r = rq.pop_front();
          chk("score_p0", score_p0, r.s0);
          chk("score_p1", score_p1, r.s1);
          chk("current_player", current_player, r.pl);
          chk("game_over", game_over, r.go);
          chk("white_respawn", white_respawn, r.rs);
          chk("power_cleared", power, 0);
        end
      end
      if (strike) begin
        if (sq.size() == 0) miss("strike_unexpected");
        else begin
          strike_t s;
          s = sq.pop_front();
          chk("strike_vx", vx, s.vx);
          chk("strike_vy", vy, s.vy);
          chk("strike_power", power, s.pw);
        end
      end
      if (state_o == 3'd4) begin
        if (eq.size() == 0) miss("eval_unexpected");
        else chk("eval_cycle", cyc, eq.pop_front());
        pend = 1'b1;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, ax, ay;
    logic [3:0] pa, pb, ps, pd;
    model_reset();
    repeat (3) step();
    chk("rst_strike", strike, 0);
    chk("rst_vx", vx, 0);
    chk("rst_vy", vy, 0);
    chk("rst_respawn", white_respawn, 0);
    chk("rst_player", current_player, 0);
    chk("rst_s0", score_p0, 0);
    chk("rst_s1", score_p1, 0);
    chk("rst_power", power, 0);
    chk("rst_state", state_o, 0);
    chk("rst_go", game_over, 0);
    resetN = 1'b1;
    step();

    shot(10, 2, -1, 20, 0, 1, 4'b0000, 4'b0, 4'b0, 4'b0);
    shot(40, 1, 0, 3, 0, 0, 4'b0000, 4'b0, 4'b0, 4'b0);
    shot(int'($urandom_range(1, 20)), 3, 2, 2, 0, 0,
         4'b0000, 4'b0, 4'b0110, 4'b0);
    shot(int'($urandom_range(1, 20)), -4, 4, 1, 0, 0,
         4'b0000, 4'b0, 4'b1001, 4'b0);

    btn = 1'b1;
    repeat (4) begin sof = 1'b1; step(); sof = 1'b0; step(); end
    btn = 1'b0;
    repeat (3) step();
    chk("go_hold_state", state_o, 5);
    chk("go_hold_flag", game_over, 1);

    do_reset();
    chk("go_reset_state", state_o, 0);
    chk("go_reset_s0", score_p0, 0);

    mov = 4'b0100; btn = 1'b1;
    step(); step();
    chk("press_moving_ignored", state_o, 0);
    btn = 1'b0; step(); mov = '0; step();

    btn = 1'b1; step();
    repeat (12) begin sof = 1'b1; step(); sof = 1'b0; step(); end
    chk("charge_power", power, 12);
    resetN = 1'b0;
    #2;
    chk("async_rst_power", power, 0);
    chk("async_rst_state", state_o, 0);
    btn = 1'b0;
    step(); step();
    resetN = 1'b1;
    model_reset();
    repeat (10) step();
    chk("post_rst_state", state_o, 0);

    shot(5, -3, 4, 0, 1, 0, 4'b0010, 4'b0, 4'b0, 4'b1000);

    for (int k = 0; k < 25; k++) begin
      h  = int'($urandom_range(0, 30));
      ax = int'($urandom_range(0, 8)) - 4;
      ay = int'($urandom_range(0, 8)) - 4;
      pd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      ps = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      pa = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      pb = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      shot(h, ax, ay, int'($urandom_range(0, 6)), 0,
           1'($urandom_range(0, 1)), pd, ps, pa, pb);
      if (m_go) begin
        chk("rand_go_state", state_o, 5);
        do_reset();
      end
    end

    repeat (5) step();
    chk("strike_queue_drained", sq.size(), 0);
    chk("eval_queue_drained", eq.size(), 0);
    chk("result_queue_drained", rq.size(), 0);
    chk("respawn_count", seen_resp, exp_resp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
